downcounter_bcd4: RTL and testbench

//  4-digit BCD countdown timer (MM:SS, digits s1000 s100 : s10 s1); down-counting companion
//  to the 4-digit BCD up-counter used for the stopwatch display.

---
 rtl/downcounter_bcd4_if.sv | 33 +++
 rtl/downcounter_bcd4.sv | 134 +++++++++++++
 tb/tb_downcounter_bcd4.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/downcounter_bcd4_if.sv
// Signal bundle for the 4-digit BCD countdown timer.
//   master : control and preset side (tick generator / front panel); drives the controls and
//            reads back the digits and status
//   slave  : the counter itself
// Controls: tick, load, start, pause, ld_s1000/ld_s100/ld_s10/ld_s1 (BCD preset digits)
// Status  : s1000/s100/s10/s1 (current digits), running, done (1-cycle pulse), expired (level)
interface downcounter_bcd4_if;
  logic       tick;
  logic       load;
  logic       start;
  logic       pause;
  logic [3:0] ld_s1000;
  logic [3:0] ld_s100;
  logic [3:0] ld_s10;
  logic [3:0] ld_s1;
  logic [3:0] s1000;
  logic [3:0] s100;
  logic [3:0] s10;
  logic [3:0] s1;
  logic       running;
  logic       done;
  logic       expired;

  modport master (
    output tick, load, start, pause, ld_s1000, ld_s100, ld_s10, ld_s1,
    input  s1000, s100, s10, s1, running, done, expired
  );

  modport slave (
    input  tick, load, start, pause, ld_s1000, ld_s100, ld_s10, ld_s1,
    output s1000, s100, s10, s1, running, done, expired
  );
endinterface

// File: rtl/downcounter_bcd4.sv
// 4-digit BCD countdown timer (MM:SS as s1000 s100 : s10 s1).
// Loads a preset, decrements once per tick while running and flags expiry at 00:00.
// Ports:
//   clk   : system clock, all state on the rising edge
//   rst_n : asynchronous reset, ACTIVE-HIGH despite the name
//   bus   : downcounter_bcd4_if.slave (controls, preset digits, count digits, status)
// Parameters:
//   SEC_TENS_MAX : value reloaded into s10 on a borrow from s100 (5 for MM:SS, 9 for 99:99)
// Build options:
//   AUTO_RELOAD_EN : when defined, expiry reloads the preset and keeps running instead of
//                    stopping in DONE (expired then never asserts).
module downcounter_bcd4 #(
  parameter int unsigned SEC_TENS_MAX = 5
) (
  input logic               clk,
  input logic               rst_n,
  downcounter_bcd4_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  localparam logic [3:0] TensMax = 4'(SEC_TENS_MAX);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;        // {s1000, s100, s10, s1}
  logic [15:0] preset_q, preset_d;
  logic        done_q, done_d;

  logic [15:0] ld_clamped;
  logic [15:0] cnt_dec;
  logic        cnt_is_zero;
  logic        cnt_is_one;

  function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] mx);
    return (v > mx) ? mx : v;
  endfunction

  assign ld_clamped = {clamp(bus.ld_s1000, 4'd9), clamp(bus.ld_s100, 4'd9),
                       clamp(bus.ld_s10, TensMax), clamp(bus.ld_s1, 4'd9)};

  assign cnt_is_zero = (cnt_q == 16'h0000);
  assign cnt_is_one  = (cnt_q == 16'h0001);

  // BCD borrow chain; only used when the count is known to be non-zero.
  always_comb begin
    cnt_dec = cnt_q;
    if (cnt_q[3:0] != 4'd0) begin
      cnt_dec[3:0] = cnt_q[3:0] - 4'd1;
    end else begin
      cnt_dec[3:0] = 4'd9;
      if (cnt_q[7:4] != 4'd0) begin
        cnt_dec[7:4] = cnt_q[7:4] - 4'd1;
      end else begin
        cnt_dec[7:4] = TensMax;
        if (cnt_q[11:8] != 4'd0) begin
          cnt_dec[11:8] = cnt_q[11:8] - 4'd1;
        end else begin
          cnt_dec[11:8]  = 4'd9;
          cnt_dec[15:12] = cnt_q[15:12] - 4'd1;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    preset_d = preset_q;
    done_d   = 1'b0;
    if (bus.load) begin
      // load beats everything, including an expiring tick in the same cycle
      preset_d = ld_clamped;
      cnt_d    = ld_clamped;
      state_d  = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start && !cnt_is_zero) state_d = StRun;
        end
        StRun: begin
          // start is a no-op while running but still outranks pause
          if (!bus.start && bus.pause) begin
            state_d = StPause;
          end else if (bus.tick) begin
            if (cnt_is_one) begin
`ifdef AUTO_RELOAD_EN
              cnt_d   = preset_q;
`else
              cnt_d   = 16'h0000;
              state_d = StDone;
`endif
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_dec;
            end
          end
        end
        StPause: begin
          if (bus.start) state_d = StRun;
        end
        StDone: begin
          if (bus.start) begin
            cnt_d   = preset_q;
            state_d = (preset_q != 16'h0000) ? StRun : StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= 16'h0000;
      preset_q <= 16'h0000;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      preset_q <= preset_d;
      done_q   <= done_d;
    end
  end

  assign bus.s1000   = cnt_q[15:12];
  assign bus.s100    = cnt_q[11:8];
  assign bus.s10     = cnt_q[7:4];
  assign bus.s1      = cnt_q[3:0];
  assign bus.running = (state_q == StRun);
  assign bus.expired = (state_q == StDone);
  assign bus.done    = done_q;

endmodule

// File: tb/tb_downcounter_bcd4.sv
// Scoreboard bench for downcounter_bcd4 (SEC_TENS_MAX = 5). The driver applies one vector per
// cycle and pushes the outputs expected after the next clock edge; a monitor pops and compares.
module tb_downcounter_bcd4;

  typedef struct {
    logic [15:0] digits;
    logic        running;
    logic        done;
    logic        expired;
    string       name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t sb_q[$];
  event sample_ev;

  downcounter_bcd4_if bus ();

  downcounter_bcd4 #(
    .SEC_TENS_MAX(5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Normal sampling point: 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    ->sample_ev;
  end

  // Monitor
  initial begin
    exp_t        e;
    logic [15:0] got;
    forever begin
      @(sample_ev);
      if (sb_q.size() != 0) begin
        e   = sb_q.pop_front();
        got = {bus.s1000, bus.s100, bus.s10, bus.s1};
        checks++;
        if (got !== e.digits || bus.running !== e.running || bus.done !== e.done ||
            bus.expired !== e.expired) begin
          failures++;
          $display("FAIL %s: got digits=%h run=%b done=%b exp=%b, want digits=%h run=%b done=%b exp=%b",
                   e.name, got, bus.running, bus.done, bus.expired,
                   e.digits, e.running, e.done, e.expired);
        end
      end
    end
  end

  // One cycle: drive controls at the falling edge, expect outputs after the next rising edge.
  task automatic step(input logic t, input logic ld, input logic st, input logic ps,
                      input logic [15:0] ldv, input logic [15:0] xd, input logic xr,
                      input logic xdn, input logic xe, input string nm);
    exp_t e;
    @(negedge clk);
    bus.tick     = t;
    bus.load     = ld;
    bus.start    = st;
    bus.pause    = ps;
    bus.ld_s1000 = ldv[15:12];
    bus.ld_s100  = ldv[11:8];
    bus.ld_s10   = ldv[7:4];
    bus.ld_s1    = ldv[3:0];
    e.digits  = xd;
    e.running = xr;
    e.done    = xdn;
    e.expired = xe;
    e.name    = nm;
    sb_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    bus.tick = 1'b0; bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
    bus.ld_s1000 = 4'd0; bus.ld_s100 = 4'd0; bus.ld_s10 = 4'd0; bus.ld_s1 = 4'd0;

    // Reset state
    step(0, 0, 0, 0, 16'h0, 16'h0000, 0, 0, 0, "reset");
    @(negedge clk);
    rst_n = 1'b0;

    // 1: 00:10 counts down to 00:00
    step(0, 1, 0, 0, 16'h0010, 16'h0010, 0, 0, 0, "t1_load");
    step(0, 0, 1, 0, 16'h0, 16'h0010, 1, 0, 0, "t1_start");
    for (int k = 1; k <= 9; k++) begin
      step(1, 0, 0, 0, 16'h0, 16'(10 - k), 1, 0, 0, "t1_tick");
    end
`ifdef AUTO_RELOAD_EN
    step(1, 0, 0, 0, 16'h0, 16'h0010, 1, 1, 0, "t1_expire_reload");
    step(0, 0, 0, 0, 16'h0, 16'h0010, 1, 0, 0, "t1_after");
`else
    step(1, 0, 0, 0, 16'h0, 16'h0000, 0, 1, 1, "t1_expire");
    step(0, 0, 0, 0, 16'h0, 16'h0000, 0, 0, 1, "t1_done_one_cycle");
`endif

    // 2: borrow across the seconds/minutes boundary and across s1000
    step(0, 1, 0, 0, 16'h0100, 16'h0100, 0, 0, 0, "t2_load");
    step(0, 0, 1, 0, 16'h0, 16'h0100, 1, 0, 0, "t2_start");
    step(1, 0, 0, 0, 16'h0, 16'h0059, 1, 0, 0, "t2_borrow_s10");
    step(0, 1, 0, 0, 16'h1000, 16'h1000, 0, 0, 0, "t2_load_1000");
    step(0, 0, 1, 0, 16'h0, 16'h1000, 1, 0, 0, "t2_start_1000");
    step(1, 0, 0, 0, 16'h0, 16'h0959, 1, 0, 0, "t2_borrow_s1000");

    // 3: pause holds the count, start resumes
    step(0, 1, 0, 0, 16'h0030, 16'h0030, 0, 0, 0, "t3_load");
    step(0, 0, 1, 0, 16'h0, 16'h0030, 1, 0, 0, "t3_start");
    step(0, 0, 0, 1, 16'h0, 16'h0030, 0, 0, 0, "t3_pause");
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 0, 0, 16'h0, 16'h0030, 0, 0, 0, "t3_paused_tick");
    end
    step(0, 0, 1, 0, 16'h0, 16'h0030, 1, 0, 0, "t3_resume");
    step(1, 0, 0, 0, 16'h0, 16'h0029, 1, 0, 0, "t3_tick");
    step(1, 0, 0, 1, 16'h0, 16'h0029, 0, 0, 0, "t3_pause_drops_tick");

    // 4: zero preset cannot start; load clamping
    step(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, "t4_load_zero");
    step(0, 0, 1, 0, 16'h0, 16'h0000, 0, 0, 0, "t4_start_ignored");
    step(0, 1, 0, 0, 16'h007C, 16'h0059, 0, 0, 0, "t4_clamp_low");
    step(0, 1, 0, 0, 16'hFA7C, 16'h9959, 0, 0, 0, "t4_clamp_all");

    // 5: asynchronous reset mid-run
    step(0, 1, 0, 0, 16'h0005, 16'h0005, 0, 0, 0, "t5_load");
    step(0, 0, 1, 0, 16'h0, 16'h0005, 1, 0, 0, "t5_start");
    step(1, 0, 0, 0, 16'h0, 16'h0004, 1, 0, 0, "t5_tick");
    @(negedge clk);
    bus.tick = 1'b0; bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
    rst_n = 1'b1;
    #1;
    e.digits = 16'h0000; e.running = 1'b0; e.done = 1'b0; e.expired = 1'b0;
    e.name = "t5_async_reset";
    sb_q.push_back(e);
    ->sample_ev;
    step(0, 0, 0, 0, 16'h0, 16'h0000, 0, 0, 0, "t5_reset_held");
    @(negedge clk);
    rst_n = 1'b0;
    step(0, 0, 1, 0, 16'h0, 16'h0000, 0, 0, 0, "t5_start_after_reset");

    // 6: expiry handling and load beating an expiring tick
    step(0, 1, 0, 0, 16'h0002, 16'h0002, 0, 0, 0, "t6_load");
    step(0, 0, 1, 0, 16'h0, 16'h0002, 1, 0, 0, "t6_start");
    step(1, 0, 0, 0, 16'h0, 16'h0001, 1, 0, 0, "t6_tick1");
`ifdef AUTO_RELOAD_EN
    step(1, 0, 0, 0, 16'h0, 16'h0002, 1, 1, 0, "t6_tick2_reload");
    step(1, 0, 0, 0, 16'h0, 16'h0001, 1, 0, 0, "t6_tick3");
    step(1, 0, 0, 0, 16'h0, 16'h0002, 1, 1, 0, "t6_tick4_reload");
    step(1, 0, 0, 0, 16'h0, 16'h0001, 1, 0, 0, "t6_tick5");
`else
    step(1, 0, 0, 0, 16'h0, 16'h0000, 0, 1, 1, "t6_tick2_expire");
    step(0, 0, 0, 1, 16'h0, 16'h0000, 0, 0, 1, "t6_pause_in_done");
    step(1, 0, 0, 0, 16'h0, 16'h0000, 0, 0, 1, "t6_tick_in_done");
    step(0, 0, 1, 0, 16'h0, 16'h0002, 1, 0, 0, "t6_restart_preset");
    step(1, 0, 0, 0, 16'h0, 16'h0001, 1, 0, 0, "t6_tick3");
`endif
    step(1, 1, 0, 0, 16'h0003, 16'h0003, 0, 0, 0, "t6_load_beats_expiry");
    step(0, 0, 0, 0, 16'h0, 16'h0003, 0, 0, 0, "t6_no_done");

    // Let the monitor drain the last entry.
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending entries, want 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
